// File: rtl/screen_scanout.sv
// Screen RAM scanout: streams a 1bpp frame buffer as pixels over valid/ready.
// Define SCANOUT_FRAME_LOOP_EN for continuous refresh without start pulses.
module screen_scanout #(
  parameter logic [11:0] SCREEN_RAM_OFFSET  = 12'h100,
  parameter int          SCREEN_WIDTH_BYTES = 8,
  parameter int          SCREEN_HEIGHT      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ppu_busy,
  output logic [11:0] mem_read_address,
  output logic        mem_read_enable,
  input  logic [7:0]  mem_read_data,
  output logic        pixel,
  output logic [5:0]  pixel_x,
  output logic [4:0]  pixel_y,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        frame_start,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [7:0] LAST_BYTE =
    8'(SCREEN_WIDTH_BYTES * SCREEN_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPTURE,
    EMIT
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  byte_index, byte_index_nx;
  logic [7:0]  shift_q, shift_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic        frame_done_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      byte_index <= '0;
      shift_q    <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_index <= byte_index_nx;
      shift_q    <= shift_nx;
      bit_cnt    <= bit_cnt_nx;
      frame_done <= frame_done_nx;
    end
  end

  always_comb begin
    state_nx         = state;
    byte_index_nx    = byte_index;
    shift_nx         = shift_q;
    bit_cnt_nx       = bit_cnt;
    frame_done_nx    = 1'b0;
    mem_read_enable  = 1'b0;
    mem_read_address = '0;
    pixel            = 1'b0;
    pixel_x          = '0;
    pixel_y          = '0;
    pixel_valid      = 1'b0;
    frame_start      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          byte_index_nx = '0;
          state_nx      = FETCH;
        end
      end
      FETCH: begin
        if (!ppu_busy) begin
          mem_read_enable  = 1'b1;
          mem_read_address = SCREEN_RAM_OFFSET + 12'(byte_index);
          state_nx         = CAPTURE;
        end
      end
      CAPTURE: begin
        shift_nx   = mem_read_data;
        bit_cnt_nx = '0;
        state_nx   = EMIT;
      end
      EMIT: begin
        pixel       = shift_q[7];
        pixel_x     = {byte_index[2:0], bit_cnt};
        pixel_y     = byte_index[7:3];
        pixel_valid = 1'b1;
        frame_start = (byte_index == 8'd0) && (bit_cnt == 3'd0);
        if (pixel_ready) begin
          shift_nx   = {shift_q[6:0], 1'b0};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_index == LAST_BYTE) begin
              frame_done_nx = 1'b1;
`ifdef SCANOUT_FRAME_LOOP_EN
              byte_index_nx = '0;
              state_nx      = FETCH;
`else
              state_nx      = IDLE;
`endif
            end else begin
              byte_index_nx = byte_index + 8'd1;
              state_nx      = FETCH;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_screen_scanout.sv
// Bench for screen_scanout: frame-level pixel model, RAM model, directed checks.
// Honours SCANOUT_FRAME_LOOP_EN for the continuous-refresh build.
module tb_screen_scanout;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ppu_busy;
  logic [11:0] mem_read_address;
  logic        mem_read_enable;
  logic [7:0]  mem_read_data = 8'h00;
  logic        pixel;
  logic [5:0]  pixel_x;
  logic [4:0]  pixel_y;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        frame_start;
  logic        frame_done;
  logic        busy;

  screen_scanout dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .ppu_busy         (ppu_busy),
    .mem_read_address (mem_read_address),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data),
    .pixel            (pixel),
    .pixel_x          (pixel_x),
    .pixel_y          (pixel_y),
    .pixel_valid      (pixel_valid),
    .pixel_ready      (pixel_ready),
    .frame_start      (frame_start),
    .frame_done       (frame_done),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       p;
    logic [4:0] y;
    logic [5:0] x;
  } pix_t;

  logic [7:0] ram [0:4095];
  pix_t       exp_q [$];
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         accepted = 0;
  pix_t       last_px;

  always @(posedge clk)
    if (mem_read_enable) mem_read_data <= ram[mem_read_address];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic void build_exp();
    exp_q.delete();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++) begin
        logic [7:0] b;
        pix_t e;
        b   = ram[12'h100 + y * 8 + x / 8];
        e.p = b[7 - (x % 8)];
        e.y = 5'(y);
        e.x = 6'(x);
        exp_q.push_back(e);
      end
  endfunction

  function automatic void clear_ram();
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
  endfunction

  logic stalled = 1'b0;
  logic done_due = 1'b0;
  pix_t held;

  always @(negedge clk) begin
    if (!reset) begin
      stalled  = 1'b0;
      done_due = 1'b0;
    end else begin
      if (mem_read_enable) begin
        chk("addr_lo", 32'(mem_read_address >= 12'h100), 32'd1);
        chk("addr_hi", 32'(mem_read_address <= 12'h1FF), 32'd1);
      end
      chk("frame_done", 32'(frame_done), 32'(done_due));
      done_due = 1'b0;
      if (frame_done) done_cnt++;
      if (stalled) begin
        chk("hold_valid", 32'(pixel_valid), 32'd1);
        chk("hold_px", 32'({pixel, pixel_y, pixel_x}), 32'(held));
      end
      if (pixel_valid && pixel_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_pixel: got (%0d,%0d) want none",
                   pixel_x, pixel_y);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          chk("pixel", 32'({pixel, pixel_y, pixel_x}), 32'(e));
          chk("frame_start", 32'(frame_start),
              32'((e.x == 6'd0) && (e.y == 5'd0)));
          accepted++;
          last_px = {pixel, pixel_y, pixel_x};
          if (e.x == 6'd63 && e.y == 5'd31) begin
            done_due = 1'b1;
`ifdef SCANOUT_FRAME_LOOP_EN
            build_exp();
`endif
          end
        end
      end
      stalled = pixel_valid && !pixel_ready;
      held    = {pixel, pixel_y, pixel_x};
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_frame(input string nm);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 4000) begin
      cyc();
      n++;
    end
    if (done_cnt == d0) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_pix(input string nm, input int x, input int y);
    int n;
    n = 0;
    while (!(pixel_valid && pixel_x == 6'(x) && pixel_y == 5'(y))
           && n < 4000) begin
      cyc();
      n++;
    end
    if (n >= 4000) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic new_frame();
    build_exp();
    done_cnt = 0;
    accepted = 0;
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    ppu_busy    = 1'b0;
    pixel_ready = 1'b1;
    clear_ram();
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({mem_read_enable, mem_read_address, pixel,
                         pixel_x, pixel_y, pixel_valid, frame_start,
                         frame_done}), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // single lit pixel at the origin
    ram[12'h100] = 8'h80;
    new_frame();
    chk("a_model0", 32'(exp_q[0]), 32'({1'b1, 5'd0, 6'd0}));
    pulse_start();
    chk("a_strobe", 32'(mem_read_enable), 32'd1);
    chk("a_addr", 32'(mem_read_address), 32'h100);
    chk("a_busy", 32'(busy), 32'd1);
    cyc();
    chk("a_cap_en", 32'(mem_read_enable), 32'd0);
    chk("a_cap_valid", 32'(pixel_valid), 32'd0);
    cyc();
    chk("a_first", 32'({pixel_valid, pixel, frame_start, pixel_x, pixel_y}),
        32'({3'b111, 6'd0, 5'd0}));
    wait_frame("a");
    chk("a_count", 32'(accepted), 32'd2048);
`ifdef SCANOUT_FRAME_LOOP_EN
    begin
      int n;
      n = 0;
      while (!frame_start && n < 10) begin
        cyc();
        n++;
      end
      chk("loop_frame_start", 32'(frame_start), 32'd1);
      chk("loop_start_xy", 32'({pixel_x, pixel_y}), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("loop_rst_busy", 32'(busy), 32'd0);
`else
    repeat (3) cyc();
    chk("a_done_once", 32'(done_cnt), 32'd1);
    chk("a_idle", 32'(busy), 32'd0);
    chk("a_queue", 32'(exp_q.size()), 32'd0);

    // only the last pixel lit
    clear_ram();
    ram[12'h1FF] = 8'h01;
    new_frame();
    chk("b_model_last", 32'(exp_q[2047]), 32'({1'b1, 5'd31, 6'd63}));
    pulse_start();
    wait_frame("b");
    chk("b_count", 32'(accepted), 32'd2048);
    chk("b_last", 32'(last_px), 32'({1'b1, 5'd31, 6'd63}));
    cyc();

    // sink stalls on pixel (3,0)
    clear_ram();
    ram[12'h100] = 8'h10;
    new_frame();
    pulse_start();
    wait_pix("c", 3, 0);
    pixel_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("c_stall", 32'({pixel_valid, pixel, pixel_x, pixel_y}),
          32'({2'b11, 6'd3, 5'd0}));
      cyc();
    end
    pixel_ready = 1'b1;
    wait_frame("c");
    chk("c_count", 32'(accepted), 32'd2048);
    cyc();

    // ppu owns RAM for four FETCH cycles
    clear_ram();
    ram[12'h100] = 8'hC3;
    new_frame();
    ppu_busy = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk("d_blocked", 32'({mem_read_enable, busy}), 32'b01);
      if (i < 3) cyc();
    end
    cyc();
    ppu_busy = 1'b0;
    #1;
    chk("d_strobe", 32'(mem_read_enable), 32'd1);
    chk("d_addr", 32'(mem_read_address), 32'h100);
    wait_frame("d");
    chk("d_count", 32'(accepted), 32'd2048);
    cyc();

    // reset in the middle of a frame
    clear_ram();
    ram[12'h129] = 8'h20;
    new_frame();
    pulse_start();
    wait_pix("e", 10, 5);
    chk("e_before", 32'(pixel), 32'd1);
    reset = 1'b0;
    #1;
    chk("e_outs", 32'({mem_read_enable, mem_read_address, pixel,
                       pixel_x, pixel_y, pixel_valid, frame_start,
                       frame_done}), 32'd0);
    chk("e_busy", 32'(busy), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("e_no_done", 32'(done_cnt), 32'd0);
    new_frame();
    pulse_start();
    chk("e_addr", 32'(mem_read_address), 32'h100);
    cyc();
    cyc();
    chk("e_restart", 32'({pixel_valid, frame_start, pixel_x, pixel_y}),
        32'({2'b11, 6'd0, 5'd0}));
    wait_frame("e");
    chk("e_count", 32'(accepted), 32'd2048);
    chk("e_done_once", 32'(done_cnt), 32'd1);
`endif
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
